// File: rtl/dut_stim_pkg.sv
// Shared types and constants for the dut_stim_gen stimulus source.
// Holds the FSM state enum, pattern mode codes, LFSR taps and pattern helpers.
package dut_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0]  MODE_LFSR  = 2'd0;
    localparam logic [1:0]  MODE_WALK  = 2'd1;
    localparam logic [1:0]  MODE_COUNT = 2'd2;
    localparam logic [1:0]  MODE_CONST = 2'd3;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        if (v[0]) begin
            r = (v >> 1) ^ LFSR_TAPS;
        end else begin
            r = v >> 1;
        end
        return r;
    endfunction

    // Returns {a, b} for pair index k (only the low three bits matter).
    function automatic logic [1:0] stim_pair(input logic [1:0] mode,
                                             input logic [2:0] k_lo,
                                             input logic [1:0] lfsr_lo);
        logic [1:0] r;
        case (mode)
            MODE_LFSR:  r = {lfsr_lo[0], lfsr_lo[1]};
            MODE_WALK:  r = {~k_lo[0], (k_lo == 3'd7)};
            MODE_COUNT: r = {k_lo[0], k_lo[1]};
            MODE_CONST: r = 2'b10;
            default:    r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dut_stim_gen_if.sv
// Control/stimulus bundle between a run controller (master) and dut_stim_gen (slave).
// ones_a/ones_b exist only when DUT_STIM_ONES_EN is defined.
interface dut_stim_gen_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [LEN_W-1:0] length;
    logic             pause;
    logic             a;
    logic             b;
    logic             valid;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] cycles;
`ifdef DUT_STIM_ONES_EN
    logic [LEN_W-1:0] ones_a;
    logic [LEN_W-1:0] ones_b;

    modport master (output start, mode, length, pause,
                    input  a, b, valid, busy, done, cycles, ones_a, ones_b);
    modport slave  (input  start, mode, length, pause,
                    output a, b, valid, busy, done, cycles, ones_a, ones_b);
`else
    modport master (output start, mode, length, pause,
                    input  a, b, valid, busy, done, cycles);
    modport slave  (input  start, mode, length, pause,
                    output a, b, valid, busy, done, cycles);
`endif
endinterface

// File: rtl/dut_stim_lfsr.sv
// 16-bit Galois LFSR with seed load and step enable.
// o_cur is the value to use for the pair emitted on this edge (SEED when loading).
module dut_stim_lfsr
    import dut_stim_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_cur
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_base;

    // Select the value this edge works from: fresh seed on load, else the held state.
    always_comb begin
        if (i_load) begin
            w_base = SEED;
        end else begin
            w_base = r_state;
        end
    end

    // Advance once per emission; a load with no emission just parks the seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= lfsr_next(w_base);
        end else if (i_load) begin
            r_state <= SEED;
        end else begin
            r_state <= r_state;
        end
    end

    assign o_cur = w_base;

endmodule

// File: rtl/dut_stim_gen.sv
// Stimulus generator for the DUT a/b inputs: start/pause/done controlled pattern runs.
// Optional per-bit ones counters are built when DUT_STIM_ONES_EN is defined.
module dut_stim_gen
    import dut_stim_pkg::*;
#(
    parameter int                LEN_W  = 16,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset,
    dut_stim_gen_if.slave  bus
);

    state_e           r_state;
    logic [1:0]       r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cycles;
    logic             r_a;
    logic             r_b;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_emit;
    logic [1:0]       w_mode;
    logic [LEN_W-1:0] w_k;
    logic [LFSR_W-1:0] w_lfsr;
    logic [1:0]       w_pair;

    // Decide whether a pair leaves this edge, and which index/mode it uses.
    always_comb begin
        w_load = 1'b0;
        w_emit = 1'b0;
        w_mode = r_mode;
        w_k    = r_cycles;
        case (r_state)
            IDLE: begin
                w_load = bus.start;
                w_emit = bus.start && (bus.length != {LEN_W{1'b0}});
                w_mode = bus.mode;
                w_k    = {LEN_W{1'b0}};
            end
            RUN:     w_emit = (r_cycles != r_len) && !bus.pause;
            HOLD:    w_emit = !bus.pause;
            default: w_emit = 1'b0;
        endcase
        w_pair = stim_pair(w_mode, w_k[2:0], w_lfsr[1:0]);
    end

    dut_stim_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_emit),
        .o_cur  (w_lfsr)
    );

    // Run FSM and registered outputs; the run-length check takes priority over pause.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mode   <= 2'd0;
            r_len    <= {LEN_W{1'b0}};
            r_cycles <= {LEN_W{1'b0}};
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= w_emit;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_len  <= bus.length;
                        if (bus.length != {LEN_W{1'b0}}) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (r_cycles == r_len) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (bus.pause) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.pause) begin
                        r_state <= RUN;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_emit) begin
                r_a      <= w_pair[1];
                r_b      <= w_pair[0];
                r_cycles <= w_k + {{(LEN_W-1){1'b0}}, 1'b1};
            end else if (w_load) begin
                r_cycles <= {LEN_W{1'b0}};
            end
        end
    end

`ifdef DUT_STIM_ONES_EN
    logic [LEN_W-1:0] r_ones_a;
    logic [LEN_W-1:0] r_ones_b;
    logic [LEN_W-1:0] w_ones_a_base;
    logic [LEN_W-1:0] w_ones_b_base;

    // The accepted start both clears the counts and may count its own first pair.
    always_comb begin
        if (w_load) begin
            w_ones_a_base = {LEN_W{1'b0}};
            w_ones_b_base = {LEN_W{1'b0}};
        end else begin
            w_ones_a_base = r_ones_a;
            w_ones_b_base = r_ones_b;
        end
    end

    // Count emitted ones on each stimulus bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ones_a <= {LEN_W{1'b0}};
            r_ones_b <= {LEN_W{1'b0}};
        end else if (w_emit) begin
            r_ones_a <= w_ones_a_base + {{(LEN_W-1){1'b0}}, w_pair[1]};
            r_ones_b <= w_ones_b_base + {{(LEN_W-1){1'b0}}, w_pair[0]};
        end else begin
            r_ones_a <= w_ones_a_base;
            r_ones_b <= w_ones_b_base;
        end
    end

    assign bus.ones_a = r_ones_a;
    assign bus.ones_b = r_ones_b;
`endif

    assign bus.a      = r_a;
    assign bus.b      = r_b;
    assign bus.valid  = r_valid;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.cycles = r_cycles;

endmodule
